// File: rtl/cmd_phase_controller.sv
// rtl/cmd_phase_controller.sv - SD CMD-line transaction sequencer: frame build, CRC7, serializer handshake, response capture/check
module cmd_phase_controller #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 8
) (
    input  logic        sd_clock,
    input  logic        reset,
    input  logic        new_command,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] cmd_argument,
    input  logic        response_expected,
    output logic [47:0] tx_parallel,
    output logic        tx_load_send,
    output logic        tx_enable,
    input  logic        tx_complete,
    input  logic        cmd_in,
    output logic        busy,
    output logic        command_done,
    output logic [47:0] response,
    output logic        timeout_error,
    output logic        crc_error
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_CRC_CALC  = 3'd1;
    localparam logic [2:0] S_LOAD      = 3'd2;
    localparam logic [2:0] S_SEND      = 3'd3;
    localparam logic [2:0] S_WAIT_RESP = 3'd4;
    localparam logic [2:0] S_RECV      = 3'd5;
    localparam logic [2:0] S_CHECK     = 3'd6;
    localparam logic [2:0] S_DONE      = 3'd7;

    localparam logic [CNT_W-1:0] LAST_CRC_BIT = CNT_W'(39);
    localparam logic [CNT_W-1:0] CRC_BITS     = CNT_W'(40);
    localparam logic [CNT_W-1:0] LAST_RX_BIT  = CNT_W'(47);
    localparam logic [CNT_W-1:0] LAST_WAIT    = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [6:0]       crc;
    logic [6:0]       crc_next;
    logic [5:0]       idx_q;
    logic [31:0]      arg_q;
    logic             resp_exp_q;
    logic [39:0]      tx_shift;
    logic             crc_bit;

    function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
        logic fb;
        fb = c[6] ^ b;
        return {c[5:3], c[2] ^ fb, c[1:0], fb};
    endfunction

    // The same CRC engine serves the outgoing frame and the incoming response.
    assign crc_bit  = (state == S_CRC_CALC) ? tx_shift[39] : cmd_in;
    assign crc_next = crc7_step(crc, crc_bit);

    always_ff @(posedge sd_clock or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            cnt           <= '0;
            crc           <= '0;
            idx_q         <= '0;
            arg_q         <= '0;
            resp_exp_q    <= 1'b0;
            tx_shift      <= '0;
            tx_parallel   <= '0;
            tx_load_send  <= 1'b0;
            tx_enable     <= 1'b0;
            busy          <= 1'b0;
            command_done  <= 1'b0;
            response      <= '0;
            timeout_error <= 1'b0;
            crc_error     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    command_done <= 1'b0;
                    if (new_command) begin
                        idx_q         <= cmd_index;
                        arg_q         <= cmd_argument;
                        resp_exp_q    <= response_expected;
                        tx_shift      <= {2'b01, cmd_index, cmd_argument};
                        crc           <= '0;
                        cnt           <= '0;
                        timeout_error <= 1'b0;
                        crc_error     <= 1'b0;
                        response      <= '0;
                        busy          <= 1'b1;
                        state         <= S_CRC_CALC;
                    end
                end
                S_CRC_CALC: begin
                    crc      <= crc_next;
                    tx_shift <= {tx_shift[38:0], 1'b0};
                    cnt      <= cnt + 1'b1;
                    // Frame and strobe are registered on entry so they are valid throughout LOAD.
                    if (cnt == LAST_CRC_BIT) begin
                        tx_parallel  <= {2'b01, idx_q, arg_q, crc_next, 1'b1};
                        tx_load_send <= 1'b1;
                        tx_enable    <= 1'b1;
                        cnt          <= '0;
                        state        <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    tx_load_send <= 1'b0;
                    state        <= S_SEND;
                end
                S_SEND: begin
                    if (tx_complete) begin
                        tx_enable    <= 1'b0;
                        crc          <= '0;
                        cnt          <= '0;
                        command_done <= ~resp_exp_q;
                        state        <= resp_exp_q ? S_WAIT_RESP : S_DONE;
                    end
                end
                S_WAIT_RESP: begin
                    if (!cmd_in) begin
                        response <= {response[46:0], 1'b0};
                        crc      <= crc_next;
                        cnt      <= CNT_W'(1);
                        state    <= S_RECV;
                    end else if (cnt == LAST_WAIT) begin
                        timeout_error <= 1'b1;
                        command_done  <= 1'b1;
                        state         <= S_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RECV: begin
                    response <= {response[46:0], cmd_in};
                    if (cnt < CRC_BITS) begin
                        crc <= crc_next;
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_RX_BIT) begin
                        state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    crc_error    <= (crc != response[7:1]) | ~response[0];
                    command_done <= 1'b1;
                    state        <= S_DONE;
                end
                S_DONE: begin
                    command_done <= 1'b0;
                    busy         <= 1'b0;
                    state        <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/cmd_phase_controller.md
Name: cmd_phase_controller

Overview:
Sequences one SD CMD-line transaction end to end.
- Transmit side: builds the 48-bit command frame, computing CRC7 serially. It then drives the existing parallel-to-serial CMD wrapper through load_send/enable and waits for its complete flag.
- Receive side: optionally waits for the card's 48-bit response on the CMD line, shifts it in, and checks its CRC7 and end bit.
- Sits between the host register/command block and the CMD serializer, in the sd_clock domain.

Parameters:
TIMEOUT_CYCLES, 64, sd_clock cycles to wait in WAIT_RESP for a response start bit (must be ≥ 2).
CNT_W, 8, width of internal bit/timeout counters (must hold max(48, TIMEOUT_CYCLES)).

Ports:
sd_clock  in  1  single clock; all logic on rising edge.
reset  in  1  asynchronous, active-high reset.
new_command  in  1  request pulse/level; sampled only in IDLE.
cmd_index  in  6  command index, captured with new_command.
cmd_argument  in  32  command argument, captured with new_command.
response_expected  in  1  1 = receive 48-bit response; captured with new_command.
tx_parallel  out  48  frame to serializer.
tx_load_send  out  1  one-cycle load strobe to serializer.
tx_enable  out  1  serializer enable, held through transmission.
tx_complete  in  1  serializer finished shifting the frame.
cmd_in  in  1  serial CMD line from card (idle high).
busy  out  1  high in every state except IDLE.
command_done  out  1  one-cycle pulse at end of transaction.
response  out  48  last received response, MSB first received.
timeout_error  out  1  no start bit within TIMEOUT_CYCLES.
crc_error  out  1  response CRC7 mismatch or end bit ≠ 1.

Behaviour:
Reset values (asynchronous on reset high):
- All outputs = 0.
- State = IDLE, counters = 0, CRC register = 0.

Frame layout:
- [47]=0, [46]=1, [45:40]=cmd_index, [39:8]=cmd_argument, [7:1]=CRC7, [0]=1.

CRC7 rule:
- Polynomial x^7+x^3+1, init 0, MSB-first over frame bits 47..8 (40 bits).
- Per bit b: fb = crc[6]^b; next = {crc[5:3], crc[2]^fb, crc[1:0], fb}.

State machine:
- IDLE:
  - On new_command=1, capture index/argument/response_expected, clear crc and counter.
  - Clear timeout_error, crc_error, and response.
  - Go to CRC_CALC.
  - new_command in any other state is ignored (not queued).
- CRC_CALC: one bit per cycle for exactly 40 cycles, then LOAD.
- LOAD:
  - Drive tx_parallel with the full frame (held stable until the next command).
  - tx_load_send=1 for exactly this one cycle, tx_enable=1.
  - Go to SEND.
- SEND:
  - tx_enable=1 until tx_complete=1 is sampled; then tx_enable=0.
  - If response_expected=1, go to WAIT_RESP; else go to DONE.
  - No timeout in SEND.
- WAIT_RESP:
  - Counter increments each cycle.
  - cmd_in=0 sampled → bit 47 received (0); go to RECV with bit count 1.
  - Counter reaching TIMEOUT_CYCLES with cmd_in still high → timeout_error=1, go to DONE.
  - A start bit on the same cycle the count expires wins (go to RECV).
- RECV:
  - Shift cmd_in into response LSB-first-in (first bit ends at [47]).
  - Feed bits 47..8 into CRC.
  - After 48 bits total, go to CHECK.
- CHECK (1 cycle): crc_error = (crc ≠ response[7:1]) | (response[0] ≠ 1). Go to DONE.
- DONE: command_done=1 for one cycle; go to IDLE.
  - busy drops in the cycle after DONE.
  - Error flags and response are held until the next accepted command.

Latency (no response): new_command sampled at edge T → LOAD at T+41 → SEND from T+42.

Reset mid-operation:
- Immediate return to IDLE.
- tx_enable and tx_load_send low; no command_done pulse.

Test Plan:
1. CMD0, argument 0x00000000, response_expected=0 → tx_parallel=0x400000000095; tx_load_send high exactly 1 cycle; command_done 1 cycle after tx_complete; busy low afterwards; no errors.
2. CMD8, argument 0x000001AA, response_expected=1; bench serializer asserts tx_complete; card model sends a valid 48-bit R7 (CRC computed by model) after 10 idle cycles → tx_parallel=0x48000001AA87; response equals the sent bits; crc_error=0; timeout_error=0.
3. Same as 2, but card flips response bit 20 → crc_error=1, command_done pulses, response holds the corrupted value.
4. response_expected=1, cmd_in held high → timeout_error=1 and command_done exactly TIMEOUT_CYCLES cycles after entering WAIT_RESP.
5. new_command pulsed again during CRC_CALC and SEND → ignored; only one frame loaded; next command accepted after IDLE and clears the previous error flags.
6. reset asserted mid-SEND and mid-RECV → all outputs 0 asynchronously; tx_enable low; no command_done; a subsequent CMD0 completes normally.
